// File: rtl/dds_voice_accum.sv
// Multi-voice DDS phase accumulator: per-voice phase RAM, one read-modify-write per request.
// Optional macro DDS_WRAP_FLAG_EN adds the out_wrap carry flag output.
module dds_voice_accum #(
  parameter int NUM_VOICES = 64,
  parameter int VOICE_W    = 8,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 10,
  parameter int OUT_LSB    = 22
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VOICE_W-1:0] in_voice,
  input  logic [ACC_W-1:0]   in_delta,
  input  logic               in_clear,
  input  logic               clear_all,
  output logic               busy,
  output logic               out_valid,
  output logic [VOICE_W-1:0] out_voice,
  output logic [OUT_W-1:0]   out_phase
`ifdef DDS_WRAP_FLAG_EN
  ,
  output logic               out_wrap
`endif
);

  localparam int AW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [VOICE_W:0] NUM_V = (VOICE_W+1)'(NUM_VOICES);
  localparam logic [AW-1:0] LAST = AW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {CLEAR, RUN, DRAIN} state_t;

  state_t state;
  logic [AW-1:0] sweep;
  logic drain_cnt;

  logic [ACC_W-1:0] mem [NUM_VOICES];
  logic [ACC_W-1:0] rd_data;
  logic [ACC_W-1:0] fwd_data;
  logic [VOICE_W-1:0] s1_voice;
  logic [ACC_W-1:0] s1_delta;
  logic s1_clear;
  logic s1_valid;
  logic s1_write;
  logic s1_fwd;

  logic accept;
  logic in_range;
  logic [AW-1:0] rd_addr;
  logic [ACC_W-1:0] prior;
  logic [ACC_W-1:0] sum;

  assign accept   = in_valid && in_ready;
  assign in_range = {1'b0, in_voice} < NUM_V;
  assign rd_addr  = in_range ? in_voice[AW-1:0] : '0;

  // Forwarded sum covers the S1 write landing on the same edge as this read.
  always_comb begin
    prior = rd_data;
    if (s1_fwd) prior = fwd_data;
    if (s1_clear) prior = '0;
  end

`ifdef DDS_WRAP_FLAG_EN
  logic carry;
  always_comb {carry, sum} = {1'b0, prior} + {1'b0, s1_delta};
`else
  always_comb sum = prior + s1_delta;
`endif

  // Phase RAM and the S0 capture registers carry no reset; the sweep zeroes the RAM.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[sweep] <= '0;
    else if (s1_write)
      mem[s1_voice[AW-1:0]] <= sum;
    if (accept) begin
      rd_data  <= mem[rd_addr];
      fwd_data <= sum;
      s1_voice <= in_voice;
      s1_delta <= in_delta;
      s1_clear <= in_clear;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= CLEAR;
      sweep     <= '0;
      drain_cnt <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b1;
      s1_valid  <= 1'b0;
      s1_write  <= 1'b0;
      s1_fwd    <= 1'b0;
      out_valid <= 1'b0;
      out_voice <= '0;
      out_phase <= '0;
`ifdef DDS_WRAP_FLAG_EN
      out_wrap  <= 1'b0;
`endif
    end else begin
      s1_valid  <= accept;
      s1_write  <= accept && in_range;
      s1_fwd    <= accept && s1_valid && (s1_voice == in_voice);
      out_valid <= s1_write;
      if (s1_write) begin
        out_voice <= s1_voice;
        out_phase <= sum[OUT_LSB+OUT_W-1:OUT_LSB];
`ifdef DDS_WRAP_FLAG_EN
        out_wrap  <= carry;
`endif
      end
      case (state)
        CLEAR: begin
          if (sweep == LAST) begin
            state    <= RUN;
            sweep    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            sweep <= sweep + AW'(1);
          end
        end
        RUN: begin
          if (clear_all) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state <= CLEAR;
            sweep <= '0;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: begin
          state    <= CLEAR;
          sweep    <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_voice_accum.sv
// Randomized self-checking bench for dds_voice_accum against a per-voice phase array model.
// Honours DDS_WRAP_FLAG_EN when defined.
module tb_dds_voice_accum;

  localparam int NV   = 64;
  localparam int MAXN = 80;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_voice;
  logic [31:0] in_delta;
  logic        in_clear;
  logic        clear_all;
  logic        busy;
  logic        out_valid;
  logic [7:0]  out_voice;
  logic [9:0]  out_phase;
`ifdef DDS_WRAP_FLAG_EN
  logic        out_wrap;
`endif

  dds_voice_accum dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_voice(in_voice),
    .in_delta(in_delta),
    .in_clear(in_clear),
    .clear_all(clear_all),
    .busy(busy),
    .out_valid(out_valid),
    .out_voice(out_voice),
    .out_phase(out_phase)
`ifdef DDS_WRAP_FLAG_EN
    ,
    .out_wrap(out_wrap)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] model_phase [NV];

  logic        q_valid [MAXN];
  logic [7:0]  q_voice [MAXN];
  logic [31:0] q_delta [MAXN];
  logic        q_clear [MAXN];

  logic        exp_valid [MAXN+2];
  logic [7:0]  exp_voice [MAXN+2];
  logic [9:0]  exp_phase [MAXN+2];
  logic        exp_wrap  [MAXN+2];
  logic        obs_valid [MAXN+2];
  logic [7:0]  obs_voice [MAXN+2];
  logic [9:0]  obs_phase [MAXN+2];
  logic        obs_wrap  [MAXN+2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: each voice phase is a plain mod-2^32 running sum; clear restarts it at the delta.
  task automatic model_apply(input logic [7:0] v, input logic [31:0] d, input logic c, input int idx);
    logic [32:0] total;
    if (int'(v) >= NV) return;
    if (c) total = {1'b0, d};
    else   total = {1'b0, model_phase[v]} + {1'b0, d};
    model_phase[v] = total[31:0];
    exp_valid[idx] = 1'b1;
    exp_voice[idx] = v;
    exp_phase[idx] = total[31:22];
    exp_wrap[idx]  = total[32];
  endtask

  task automatic drive_sequence(input int n);
    for (int k = 0; k <= n + 1; k++) exp_valid[k] = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      if (k < n) begin
        in_valid = q_valid[k];
        in_voice = q_voice[k];
        in_delta = q_delta[k];
        in_clear = q_clear[k];
        if (q_valid[k]) model_apply(q_voice[k], q_delta[k], q_clear[k], k + 1);
      end else begin
        in_valid = 1'b0;
        in_clear = 1'b0;
      end
      tick();
      obs_valid[k] = out_valid;
      obs_voice[k] = out_voice;
      obs_phase[k] = out_phase;
`ifdef DDS_WRAP_FLAG_EN
      obs_wrap[k]  = out_wrap;
`else
      obs_wrap[k]  = 1'b0;
`endif
    end
  endtask

  task automatic load_req(input int i, input logic [7:0] v, input logic [31:0] d, input logic c);
    q_valid[i] = 1'b1;
    q_voice[i] = v;
    q_delta[i] = d;
    q_clear[i] = c;
  endtask

  task automatic test_reset();
    int cnt;
    int busy_bad;
    reset_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl got in_ready=%b busy=%b expected 0 1", in_ready, busy);
    end
    tests_run++;
    if (out_valid !== 1'b0 || out_voice !== 8'd0 || out_phase !== 10'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out got v=%b voice=%0d phase=%h expected 0 0 000", out_valid, out_voice, out_phase);
    end
    reset_n = 1'b1;
    cnt = 0;
    busy_bad = 0;
    do begin
      tick();
      cnt++;
      if (in_ready !== 1'b1 && busy !== 1'b1) busy_bad++;
    end while (in_ready !== 1'b1 && cnt < 300);
    tests_run++;
    if (cnt != NV) begin
      tests_failed++;
      $display("[TB] FAIL sweep_len got %0d cycles expected %0d", cnt, NV);
    end
    tests_run++;
    if (busy !== 1'b0 || busy_bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL sweep_busy got busy=%b low_during_sweep=%0d expected 0 0", busy, busy_bad);
    end
  endtask

  task automatic test_forwarding();
    for (int i = 0; i < 4; i++) load_req(i, 8'd3, 32'h0040_0000, 1'b0);
    drive_sequence(4);
    for (int k = 0; k <= 5; k++) begin
      tests_run++;
      if (obs_valid[k] !== exp_valid[k] ||
          (exp_valid[k] && (obs_voice[k] !== exp_voice[k] || obs_phase[k] !== exp_phase[k]))) begin
        tests_failed++;
        $display("[TB] FAIL forward k=%0d got v=%b voice=%0d phase=%h expected v=%b voice=%0d phase=%h",
                 k, obs_valid[k], obs_voice[k], obs_phase[k], exp_valid[k], exp_voice[k], exp_phase[k]);
      end
    end
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 6; i++)
      load_req(i, (i % 2 == 0) ? 8'd0 : 8'd1, (i % 2 == 0) ? 32'h0040_0000 : 32'h0080_0000, 1'b0);
    drive_sequence(6);
    for (int k = 0; k <= 7; k++) begin
      tests_run++;
      if (obs_valid[k] !== exp_valid[k] ||
          (exp_valid[k] && (obs_voice[k] !== exp_voice[k] || obs_phase[k] !== exp_phase[k]))) begin
        tests_failed++;
        $display("[TB] FAIL interleave k=%0d got v=%b voice=%0d phase=%h expected v=%b voice=%0d phase=%h",
                 k, obs_valid[k], obs_voice[k], obs_phase[k], exp_valid[k], exp_voice[k], exp_phase[k]);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) load_req(i, 8'd5, 32'h8000_0000, 1'b0);
    drive_sequence(3);
    for (int k = 0; k <= 4; k++) begin
      tests_run++;
      if (obs_valid[k] !== exp_valid[k] ||
          (exp_valid[k] && (obs_voice[k] !== exp_voice[k] || obs_phase[k] !== exp_phase[k]))) begin
        tests_failed++;
        $display("[TB] FAIL wrap_phase k=%0d got v=%b phase=%h expected v=%b phase=%h",
                 k, obs_valid[k], obs_phase[k], exp_valid[k], exp_phase[k]);
      end
`ifdef DDS_WRAP_FLAG_EN
      if (exp_valid[k]) begin
        tests_run++;
        if (obs_wrap[k] !== exp_wrap[k]) begin
          tests_failed++;
          $display("[TB] FAIL wrap_flag k=%0d got %b expected %b", k, obs_wrap[k], exp_wrap[k]);
        end
      end
`endif
    end
  endtask

  task automatic test_in_clear();
    load_req(0, 8'd3, 32'h0040_0000, 1'b1);
    load_req(1, 8'd3, 32'h0040_0000, 1'b0);
    drive_sequence(2);
    for (int k = 0; k <= 3; k++) begin
      tests_run++;
      if (obs_valid[k] !== exp_valid[k] ||
          (exp_valid[k] && (obs_voice[k] !== exp_voice[k] || obs_phase[k] !== exp_phase[k] ||
                            obs_wrap[k] !== (exp_wrap[k] & obs_wrap[k])))) begin
        tests_failed++;
        $display("[TB] FAIL in_clear k=%0d got v=%b phase=%h expected v=%b phase=%h",
                 k, obs_valid[k], obs_phase[k], exp_valid[k], exp_phase[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 60;
    for (int i = 0; i < n; i++) begin
      q_valid[i] = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: q_voice[i] = 8'($urandom_range(3, 4));
        5:             q_voice[i] = 8'($urandom_range(64, 69));
        default:       q_voice[i] = 8'($urandom_range(0, 63));
      endcase
      q_delta[i] = $urandom;
      q_clear[i] = ($urandom_range(0, 7) == 0);
    end
    drive_sequence(n);
    for (int k = 0; k <= n + 1; k++) begin
      tests_run++;
      if (obs_valid[k] !== exp_valid[k] ||
          (exp_valid[k] && (obs_voice[k] !== exp_voice[k] || obs_phase[k] !== exp_phase[k]))) begin
        tests_failed++;
        $display("[TB] FAIL random k=%0d got v=%b voice=%0d phase=%h expected v=%b voice=%0d phase=%h",
                 k, obs_valid[k], obs_voice[k], obs_phase[k], exp_valid[k], exp_voice[k], exp_phase[k]);
      end
`ifdef DDS_WRAP_FLAG_EN
      if (exp_valid[k]) begin
        tests_run++;
        if (obs_wrap[k] !== exp_wrap[k]) begin
          tests_failed++;
          $display("[TB] FAIL random_wrap k=%0d got %b expected %b", k, obs_wrap[k], exp_wrap[k]);
        end
      end
`endif
    end
  endtask

  task automatic test_clear_all();
    int k;
    int low;
    int spurious;
    int busy_bad;
    logic got_result;
    logic [31:0] d;
    d = $urandom;
    exp_valid[0] = 1'b0;
    model_apply(8'd2, d, 1'b0, 0);
    in_valid  = 1'b1;
    in_voice  = 8'd2;
    in_delta  = d;
    in_clear  = 1'b0;
    clear_all = 1'b1;
    tick();
    k = 1;
    in_voice = 8'd9;
    low = 0;
    spurious = 0;
    busy_bad = 0;
    got_result = 1'b0;
    while (k < 300) begin
      if (k == 2) begin
        got_result = out_valid;
        tests_run++;
        if (out_valid !== 1'b1 || out_voice !== 8'd2 || out_phase !== exp_phase[0]) begin
          tests_failed++;
          $display("[TB] FAIL clear_all_req got v=%b voice=%0d phase=%h expected v=1 voice=2 phase=%h",
                   out_valid, out_voice, out_phase, exp_phase[0]);
        end
      end else if (out_valid !== 1'b0) begin
        spurious++;
      end
      if (in_ready === 1'b1) break;
      low++;
      if (busy !== 1'b1) busy_bad++;
      clear_all = (k == 1 || k == 30);
      tick();
      k++;
    end
    in_valid  = 1'b0;
    clear_all = 1'b0;
    tests_run++;
    if (low != 2 + NV) begin
      tests_failed++;
      $display("[TB] FAIL clear_all_len got %0d cycles expected %0d", low, 2 + NV);
    end
    tests_run++;
    if (spurious != 0 || busy_bad != 0 || got_result !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL clear_all_side got spurious=%0d busy_low=%0d result=%b expected 0 0 1",
               spurious, busy_bad, got_result);
    end
    for (int i = 0; i < NV; i++) model_phase[i] = 32'd0;
  endtask

  task automatic test_after_clear();
    for (int i = 0; i < NV; i++) load_req(i, 8'(i), $urandom, 1'b0);
    load_req(NV, 8'd70, $urandom, 1'b0);
    drive_sequence(NV + 1);
    for (int k = 0; k <= NV + 2; k++) begin
      tests_run++;
      if (obs_valid[k] !== exp_valid[k] ||
          (exp_valid[k] && (obs_voice[k] !== exp_voice[k] || obs_phase[k] !== q_delta[k-1][31:22]))) begin
        tests_failed++;
        $display("[TB] FAIL after_clear k=%0d got v=%b voice=%0d phase=%h expected v=%b voice=%0d phase=%h",
                 k, obs_valid[k], obs_voice[k], obs_phase[k], exp_valid[k], exp_voice[k], exp_phase[k]);
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_voice  = 8'd0;
    in_delta  = 32'd0;
    in_clear  = 1'b0;
    clear_all = 1'b0;
    for (int i = 0; i < NV; i++) model_phase[i] = 32'd0;
    test_reset();
    test_forwarding();
    test_interleave();
    test_wrap();
    test_in_clear();
    test_back_to_back();
    test_clear_all();
    test_after_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dds_voice_accum.md
Name: dds_voice_accum

Overview:
- Multi-voice DDS phase accumulator for the synth voice path.
- Keeps one ACC_W-bit phase per voice in an internal synchronous-read RAM and applies one read-modify-write per accepted request.
- Returns the truncated phase to the waveform lookup stage.
- Generalises the single-port per-voice accumulator with these additions: parametrised voice count and widths, valid/ready input, same-voice back-to-back forwarding, per-voice phase clear, and a self-sequenced bulk clear FSM (the RAM itself has no reset).

Parameters:
- NUM_VOICES, 64: number of voices; any value 2..256.
- VOICE_W, 8: voice index width; must satisfy 2^VOICE_W >= NUM_VOICES.
- ACC_W, 32: phase accumulator width.
- OUT_W, 10: output phase width.
- OUT_LSB, 22: LSB of the output slice taken from the accumulator sum; OUT_LSB+OUT_W <= ACC_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_voice  in  VOICE_W  voice to advance.
- in_delta  in  ACC_W  phase increment.
- in_clear  in  1  restart this voice's phase at 0 (note-on).
- clear_all  in  1  single-cycle pulse: zero every voice phase.
- busy  out  1  high while in CLEAR or DRAIN state.
- out_valid  out  1  result valid, single-cycle per request.
- out_voice  out  VOICE_W  voice of the result.
- out_phase  out  OUT_W  new phase, bits [OUT_LSB+OUT_W-1:OUT_LSB].

Behaviour:
- Reset values: out_valid=0, out_voice=0, out_phase=0, in_ready=0, busy=1; FSM=CLEAR with sweep counter at 0; all pipeline valids cleared.
- Asserting reset_n low at any time aborts everything and restarts the sweep after release.
- FSM states: CLEAR, RUN, DRAIN.
  - CLEAR: writes 0 to address = counter, one address per cycle, 0..NUM_VOICES-1. After the last write → RUN. Lasts exactly NUM_VOICES cycles. in_ready=0, busy=1.
  - RUN: in_ready=1, busy=0. clear_all sampled high → DRAIN next cycle.
  - DRAIN: exactly 2 cycles, in_ready=0, busy=1, so in-flight requests finish their writes. Then → CLEAR with counter=0.
  - clear_all while in CLEAR or DRAIN is ignored.
- clear_all and in_valid high in the same RUN cycle: the request is accepted and completes normally, then the clear runs.
- Pipeline, for a request accepted in cycle T (in_valid && in_ready):
  - S0 (cycle T): RAM read at in_voice; capture voice, delta, clear.
  - S1 (cycle T+1): sum = (clear ? 0 : prior) + delta, with carry discarded (mod 2^ACC_W). Write sum to RAM at voice on the T+1 edge.
  - out_* registered, visible in cycle T+2. Latency 2; throughput 1 per cycle.
- in_clear: the stored phase becomes in_delta (i.e. phase 0 plus delta). out_phase reflects that value.
- Forwarding: if the voice in S0 equals the voice in S1 with S1 valid, the prior value is S1's sum, not the RAM data.
  - Back-to-back increments to one voice must accumulate exactly, with no lost updates.
  - Requests two or more cycles apart read the RAM normally.
- in_voice >= NUM_VOICES: the handshake completes, but there is no RAM write and no out_valid.
- out_valid is low in every cycle without a completing request.
- No backpressure on the output.

Optional Feature:
- Macro DDS_WRAP_FLAG_EN.
- Defined:
  - Adds output port out_wrap (1 bit, reset 0), registered alongside out_valid.
  - out_wrap=1 when prior + delta carries out of ACC_W bits. It is always 0 for in_clear requests.
  - Intended as an oscillator hard-sync source.
- Undefined: port absent and no carry logic; all other behaviour identical.

Test Plan:
- Release reset_n → in_ready=0 and busy=1 for exactly 64 cycles (NUM_VOICES=64), then in_ready=1 and busy=0.
- Voice 3, in_delta=0x0040_0000, four consecutive cycles → out_phase 0x001,0x002,0x003,0x004 on consecutive cycles starting at T+2 (exercises forwarding).
- Alternate voice 0 (delta 0x0040_0000) and voice 1 (delta 0x0080_0000), 3 rounds each → voice 0: 1,2,3; voice 1: 2,4,6. No cross-talk.
- Voice 5, in_delta=0x8000_0000, three requests → out_phase 0x200,0x000,0x200; with DDS_WRAP_FLAG_EN, out_wrap 0,1,0.
- Voice 3 after reaching phase 0x004, in_clear=1 with delta 0x0040_0000 → out_phase 0x001; next plain increment → 0x002.
- clear_all in the same cycle as an accepted voice 2 request:
  - voice 2 result appears at T+2;
  - in_ready low for 2+64 cycles;
  - afterwards every voice returns out_phase == its delta slice;
  - in_voice=70 with NUM_VOICES=64 → no out_valid.
